// File: rtl/lfsr_checker.sv
// Receive-side checker for the x^10+x^7+1 Fibonacci LFSR pattern generator.
// Self-synchronises a local LFSR copy from the incoming bit stream, then compares
// every accepted bit against the prediction. Falls back to seeding when too many
// errors land in one window.
//
// Ports:
//   clk      system clock, rising edge
//   rst_en   asynchronous active-low reset
//   sh_en    bit-valid strobe; din accepted on any clk edge with sh_en=1
//   din      serial bit from the generator (its feedback bit)
//   clr      synchronous clear of err_cnt and window counters; lock unaffected
//   locked   1 while checking
//   err_tick one-cycle pulse per mismatched bit (cycle after acceptance)
//   err_cnt  saturating mismatch count since reset/clr
//   max_tick one-cycle pulse per completed 1023-bit period while locked
module lfsr_checker #(
  parameter int unsigned LOSS_WIN = 64,
  parameter int unsigned LOSS_THR = 8,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_en,
  input  logic             sh_en,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err_tick,
  output logic [ERR_W-1:0] err_cnt,
  output logic             max_tick
);

  localparam int unsigned WinW  = $clog2(LOSS_WIN);
  // Holds 0..LOSS_WIN so the error sum never overflows before the threshold test.
  localparam int unsigned WerrW = $clog2(LOSS_WIN + 1);

  localparam logic [WinW-1:0]  WinLast = WinW'(LOSS_WIN - 1);
  localparam logic [WerrW-1:0] WerrThr = WerrW'(LOSS_THR);
  localparam logic [9:0]       PerLast = 10'd1022;

  typedef enum logic [0:0] {StSeed, StCheck} state_e;

  state_e           state_q, state_d;
  logic [9:0]       sreg_q, sreg_d;
  logic [3:0]       seed_cnt_q, seed_cnt_d;
  logic [9:0]       per_cnt_q, per_cnt_d;
  logic [WinW-1:0]  win_cnt_q, win_cnt_d;
  logic [WerrW-1:0] win_err_q, win_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_tick_q, err_tick_d;
  logic             max_tick_q, max_tick_d;

  logic             pred;
  logic             err;
  logic [9:0]       seed_sreg;
  logic             seed_done;
  logic             seed_ok;
  logic [WerrW-1:0] win_err_sum;
  logic             loss;

  assign pred        = sreg_q[9] ^ sreg_q[6];
  assign err         = sh_en && (state_q == StCheck) && (din ^ pred);
  assign seed_sreg   = {sreg_q[8:0], din};
  assign seed_done   = sh_en && (state_q == StSeed) && (seed_cnt_q == 4'd9);
  // An all-zero seed would lock the LFSR up, so it is rejected.
  assign seed_ok     = seed_done && (seed_sreg != 10'd0);
  assign win_err_sum = win_err_q + WerrW'(err);
  // clr discards a coincident error, so it can never trigger loss of lock.
  assign loss        = err && !clr && (win_err_sum >= WerrThr);

  // State register
  always_ff @(posedge clk or negedge rst_en) begin
    if (!rst_en) begin
      state_q <= StSeed;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSeed:  if (seed_ok) state_d = StCheck;
      StCheck: if (loss)    state_d = StSeed;
      default: state_d = StSeed;
    endcase
  end

  // Datapath next-state
  always_comb begin
    sreg_d     = sreg_q;
    seed_cnt_d = seed_cnt_q;
    per_cnt_d  = per_cnt_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    err_cnt_d  = err_cnt_q;
    err_tick_d = 1'b0;
    max_tick_d = 1'b0;
    if (sh_en) begin
      if (state_q == StSeed) begin
        sreg_d     = seed_sreg;
        seed_cnt_d = seed_done ? 4'd0 : seed_cnt_q + 4'd1;
        if (seed_ok) begin
          per_cnt_d = '0;
          win_cnt_d = '0;
          win_err_d = '0;
        end
      end else begin
        // Feed back the prediction, not din, so channel errors do not propagate.
        sreg_d     = {sreg_q[8:0], pred};
        err_tick_d = err;
        if (per_cnt_q == PerLast) begin
          per_cnt_d  = '0;
          max_tick_d = 1'b1;
        end else begin
          per_cnt_d = per_cnt_q + 10'd1;
        end
        if (err && (err_cnt_q != {ERR_W{1'b1}})) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        if (loss) begin
          seed_cnt_d = '0;
          per_cnt_d  = '0;
          win_cnt_d  = '0;
          win_err_d  = '0;
        end else if (win_cnt_q == WinLast) begin
          win_cnt_d = '0;
          win_err_d = WerrW'(err);
        end else begin
          win_cnt_d = win_cnt_q + WinW'(1);
          win_err_d = win_err_sum;
        end
      end
    end
    if (clr) begin
      err_cnt_d = '0;
      win_cnt_d = '0;
      win_err_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_en) begin
    if (!rst_en) begin
      sreg_q     <= '0;
      seed_cnt_q <= '0;
      per_cnt_q  <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      err_cnt_q  <= '0;
      err_tick_q <= 1'b0;
      max_tick_q <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      seed_cnt_q <= seed_cnt_d;
      per_cnt_q  <= per_cnt_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      err_cnt_q  <= err_cnt_d;
      err_tick_q <= err_tick_d;
      max_tick_q <= max_tick_d;
    end
  end

  // Outputs
  always_comb begin
    locked   = (state_q == StCheck);
    err_tick = err_tick_q;
    err_cnt  = err_cnt_q;
    max_tick = max_tick_q;
  end

endmodule
